// File: rtl/axi4_dual_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_dual_master_arbiter
// Purpose  : Two-master to one-slave AXI4 interconnect. The write path
//            (AW/W/B) and the read path (AR/R) are arbitrated independently.
//            Each grant is held for a whole burst. The master without the
//            grant is stalled.
// Options  : AXI4_ARB_FIXED_PRIO_EN selects fixed priority (M0 wins ties).
//            When it is undefined, each path uses round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_dual_master_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // master 0
    input  logic [ADDR_WIDTH-1:0] M0_AWADDR,
    input  logic [7:0]            M0_AWLEN,
    input  logic [2:0]            M0_AWSIZE,
    input  logic                  M0_AWVALID,
    output logic                  M0_AWREADY,
    input  logic [DATA_WIDTH-1:0] M0_WDATA,
    input  logic                  M0_WLAST,
    input  logic                  M0_WVALID,
    output logic                  M0_WREADY,
    output logic [1:0]            M0_BRESP,
    output logic                  M0_BVALID,
    input  logic                  M0_BREADY,
    input  logic [ADDR_WIDTH-1:0] M0_ARADDR,
    input  logic [7:0]            M0_ARLEN,
    input  logic [2:0]            M0_ARSIZE,
    input  logic                  M0_ARVALID,
    output logic                  M0_ARREADY,
    output logic [DATA_WIDTH-1:0] M0_RDATA,
    output logic [1:0]            M0_RRESP,
    output logic                  M0_RLAST,
    output logic                  M0_RVALID,
    input  logic                  M0_RREADY,
    // master 1
    input  logic [ADDR_WIDTH-1:0] M1_AWADDR,
    input  logic [7:0]            M1_AWLEN,
    input  logic [2:0]            M1_AWSIZE,
    input  logic                  M1_AWVALID,
    output logic                  M1_AWREADY,
    input  logic [DATA_WIDTH-1:0] M1_WDATA,
    input  logic                  M1_WLAST,
    input  logic                  M1_WVALID,
    output logic                  M1_WREADY,
    output logic [1:0]            M1_BRESP,
    output logic                  M1_BVALID,
    input  logic                  M1_BREADY,
    input  logic [ADDR_WIDTH-1:0] M1_ARADDR,
    input  logic [7:0]            M1_ARLEN,
    input  logic [2:0]            M1_ARSIZE,
    input  logic                  M1_ARVALID,
    output logic                  M1_ARREADY,
    output logic [DATA_WIDTH-1:0] M1_RDATA,
    output logic [1:0]            M1_RRESP,
    output logic                  M1_RLAST,
    output logic                  M1_RVALID,
    input  logic                  M1_RREADY,
    // slave
    output logic [ADDR_WIDTH-1:0] S_AWADDR,
    output logic [7:0]            S_AWLEN,
    output logic [2:0]            S_AWSIZE,
    output logic                  S_AWVALID,
    input  logic                  S_AWREADY,
    output logic [DATA_WIDTH-1:0] S_WDATA,
    output logic                  S_WLAST,
    output logic                  S_WVALID,
    input  logic                  S_WREADY,
    input  logic [1:0]            S_BRESP,
    input  logic                  S_BVALID,
    output logic                  S_BREADY,
    output logic [ADDR_WIDTH-1:0] S_ARADDR,
    output logic [7:0]            S_ARLEN,
    output logic [2:0]            S_ARSIZE,
    output logic                  S_ARVALID,
    input  logic                  S_ARREADY,
    input  logic [DATA_WIDTH-1:0] S_RDATA,
    input  logic [1:0]            S_RRESP,
    input  logic                  S_RLAST,
    input  logic                  S_RVALID,
    output logic                  S_RREADY,
    // grants
    output logic [1:0]            WR_GNT,
    output logic [1:0]            RD_GNT
);

    typedef enum logic [1:0] {WA_IDLE, WA_ADDR, WA_DATA, WA_RESP} wr_state_t;
    typedef enum logic [1:0] {RA_IDLE, RA_ADDR, RA_DATA}          rd_state_t;

    wr_state_t wr_state, wr_state_next;
    rd_state_t rd_state, rd_state_next;
    logic [1:0] wr_gnt, wr_gnt_next;
    logic [1:0] rd_gnt, rd_gnt_next;
    logic [1:0] wr_req, rd_req;
    logic [1:0] wr_pick, rd_pick;

    assign wr_req = {M1_AWVALID, M0_AWVALID};
    assign rd_req = {M1_ARVALID, M0_ARVALID};

`ifdef AXI4_ARB_FIXED_PRIO_EN
    // Fixed priority: M0 wins any tie on both paths
    always_comb begin
        wr_pick = wr_req[0] ? 2'b01 : {wr_req[1], 1'b0};
        rd_pick = rd_req[0] ? 2'b01 : {rd_req[1], 1'b0};
    end
`else
    // Last-winner pointers: 1 means M1 won the most recent grant
    logic wr_last, rd_last;

    // Round-robin: on a tie, grant the master that did not win last time
    always_comb begin
        wr_pick = (wr_req == 2'b11) ? (wr_last ? 2'b01 : 2'b10) : wr_req;
        rd_pick = (rd_req == 2'b11) ? (rd_last ? 2'b01 : 2'b10) : rd_req;
    end

    // Update each pointer when its path issues a grant; reset favours M0
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_last <= 1'b1;
            rd_last <= 1'b1;
        end else begin
            if (wr_state == WA_IDLE && wr_req != 2'b00) wr_last <= wr_pick[1];
            if (rd_state == RA_IDLE && rd_req != 2'b00) rd_last <= rd_pick[1];
        end
    end
`endif

    // Selected-master views, used by both the FSMs and the forwarding muxes
    logic wsel, rsel;
    logic aw_valid_sel, w_valid_sel, w_last_sel, b_ready_sel;
    logic ar_valid_sel, r_ready_sel;
    logic in_aw, in_w, in_b, in_ar, in_r;

    assign wsel         = wr_gnt[1];
    assign rsel         = rd_gnt[1];
    assign aw_valid_sel = wsel ? M1_AWVALID : M0_AWVALID;
    assign w_valid_sel  = wsel ? M1_WVALID  : M0_WVALID;
    assign w_last_sel   = wsel ? M1_WLAST   : M0_WLAST;
    assign b_ready_sel  = wsel ? M1_BREADY  : M0_BREADY;
    assign ar_valid_sel = rsel ? M1_ARVALID : M0_ARVALID;
    assign r_ready_sel  = rsel ? M1_RREADY  : M0_RREADY;
    assign in_aw        = (wr_state == WA_ADDR);
    assign in_w         = (wr_state == WA_DATA);
    assign in_b         = (wr_state == WA_RESP);
    assign in_ar        = (rd_state == RA_ADDR);
    assign in_r         = (rd_state == RA_DATA);

    // State and grant registers for both paths
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state <= WA_IDLE;
            rd_state <= RA_IDLE;
            wr_gnt   <= 2'b00;
            rd_gnt   <= 2'b00;
        end else begin
            wr_state <= wr_state_next;
            rd_state <= rd_state_next;
            wr_gnt   <= wr_gnt_next;
            rd_gnt   <= rd_gnt_next;
        end
    end

    // Write FSM next state: grant, address, data until WLAST, response
    always_comb begin
        wr_state_next = wr_state;
        wr_gnt_next   = wr_gnt;
        case (wr_state)
            WA_IDLE: if (wr_req != 2'b00) begin
                wr_gnt_next   = wr_pick;
                wr_state_next = WA_ADDR;
            end
            WA_ADDR: if (aw_valid_sel && S_AWREADY) wr_state_next = WA_DATA;
            WA_DATA: if (w_valid_sel && S_WREADY && w_last_sel) wr_state_next = WA_RESP;
            WA_RESP: if (S_BVALID && b_ready_sel) begin
                wr_state_next = WA_IDLE;
                wr_gnt_next   = 2'b00;
            end
            default: begin
                wr_state_next = WA_IDLE;
                wr_gnt_next   = 2'b00;
            end
        endcase
    end

    // Read FSM next state: grant, address, data until the slave's RLAST
    always_comb begin
        rd_state_next = rd_state;
        rd_gnt_next   = rd_gnt;
        case (rd_state)
            RA_IDLE: if (rd_req != 2'b00) begin
                rd_gnt_next   = rd_pick;
                rd_state_next = RA_ADDR;
            end
            RA_ADDR: if (ar_valid_sel && S_ARREADY) rd_state_next = RA_DATA;
            RA_DATA: if (S_RVALID && r_ready_sel && S_RLAST) begin
                rd_state_next = RA_IDLE;
                rd_gnt_next   = 2'b00;
            end
            default: begin
                rd_state_next = RA_IDLE;
                rd_gnt_next   = 2'b00;
            end
        endcase
    end

    // Slave-side forwarding; every field is zero outside its phase
    assign S_AWADDR  = in_aw ? (wsel ? M1_AWADDR : M0_AWADDR) : '0;
    assign S_AWLEN   = in_aw ? (wsel ? M1_AWLEN  : M0_AWLEN)  : '0;
    assign S_AWSIZE  = in_aw ? (wsel ? M1_AWSIZE : M0_AWSIZE) : '0;
    assign S_AWVALID = in_aw & aw_valid_sel;
    assign S_WDATA   = in_w  ? (wsel ? M1_WDATA  : M0_WDATA)  : '0;
    assign S_WLAST   = in_w  & w_last_sel;
    assign S_WVALID  = in_w  & w_valid_sel;
    assign S_BREADY  = in_b  & b_ready_sel;
    assign S_ARADDR  = in_ar ? (rsel ? M1_ARADDR : M0_ARADDR) : '0;
    assign S_ARLEN   = in_ar ? (rsel ? M1_ARLEN  : M0_ARLEN)  : '0;
    assign S_ARSIZE  = in_ar ? (rsel ? M1_ARSIZE : M0_ARSIZE) : '0;
    assign S_ARVALID = in_ar & ar_valid_sel;
    assign S_RREADY  = in_r  & r_ready_sel;

    // Master-side returns, gated so only the granted master sees anything
    assign M0_AWREADY = in_aw & wr_gnt[0] & S_AWREADY;
    assign M1_AWREADY = in_aw & wr_gnt[1] & S_AWREADY;
    assign M0_WREADY  = in_w  & wr_gnt[0] & S_WREADY;
    assign M1_WREADY  = in_w  & wr_gnt[1] & S_WREADY;
    assign M0_BVALID  = in_b  & wr_gnt[0] & S_BVALID;
    assign M1_BVALID  = in_b  & wr_gnt[1] & S_BVALID;
    assign M0_BRESP   = (in_b & wr_gnt[0]) ? S_BRESP : 2'b00;
    assign M1_BRESP   = (in_b & wr_gnt[1]) ? S_BRESP : 2'b00;
    assign M0_ARREADY = in_ar & rd_gnt[0] & S_ARREADY;
    assign M1_ARREADY = in_ar & rd_gnt[1] & S_ARREADY;
    assign M0_RVALID  = in_r  & rd_gnt[0] & S_RVALID;
    assign M1_RVALID  = in_r  & rd_gnt[1] & S_RVALID;
    assign M0_RLAST   = in_r  & rd_gnt[0] & S_RLAST;
    assign M1_RLAST   = in_r  & rd_gnt[1] & S_RLAST;
    assign M0_RRESP   = (in_r & rd_gnt[0]) ? S_RRESP : 2'b00;
    assign M1_RRESP   = (in_r & rd_gnt[1]) ? S_RRESP : 2'b00;
    assign M0_RDATA   = (in_r & rd_gnt[0]) ? S_RDATA : '0;
    assign M1_RDATA   = (in_r & rd_gnt[1]) ? S_RDATA : '0;

    assign WR_GNT = wr_gnt;
    assign RD_GNT = rd_gnt;

endmodule
`default_nettype wire
